fx2_emu: RTL and testbench
==========================

FX2_EMU -- requirements
Module: fx2_emu

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk_in  input  1  single clock; all state changes on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- fx2FifoSel_in  input  1  FIFO select: 0 = OUT (host->FPGA), 1 = IN (FPGA->host).
- fx2Data_io  inout  8  FIFO data bus.
- fx2Read_in  input  1  active-low read strobe.
- fx2GotData_out  output  1  high = OUT byte present on fx2Data_io.
- fx2Write_in  input  1  active-low write strobe.
- fx2GotRoom_out  output  1  high = IN FIFO accepts a byte this edge.
- fx2PktEnd_in  input  1  active-low early packet commit.
- hostCmdValid_in / hostCmdReady_out  in/out  1/1  command handshake.
- hostCmdRead_in  input  1  1 = host reads a channel, 0 = host writes it.
- hostCmdChan_in  input  7  channel 0-127.
- hostCmdCount_in  input  32  byte count.
- hostData_in / hostValid_in / hostReady_out  in/in/out  8/1/1  host write stream.
- hostData_out / hostValid_out / hostReady_in  out/out/in  8/1/1  host read stream.
- hostPktEnd_out  output  1  one-cycle pulse on packet commit.
- protoErr_out  output  1  sticky protocol-violation flag.
- busy_out  output  1  high whenever state is not S_IDLE.

Function
REQ-002 SHALL implement states S_IDLE, S_HDR, S_CNT0, S_CNT1, S_CNT2, S_CNT3, S_WDATA, S_RDATA, S_RPKT.
REQ-003 SHALL hold one OUT byte register outByte plus valid bit outValid; fx2GotData_out = outValid.
REQ-004 SHALL drive fx2Data_io with outByte iff fx2FifoSel_in = 0 and fx2Write_in = 1, else high-Z.
REQ-005 Consume event = rising edge with fx2FifoSel_in = 0, fx2Read_in = 0, outValid = 1; fx2Read_in low while outValid = 0 SHALL be ignored, with no error.
REQ-006 hostCmdReady_out SHALL be 1 only in S_IDLE; command accepted on edge with valid and ready both high.
REQ-007 On accept with count 0: no bytes SHALL be sent; remain in S_IDLE.
REQ-008 On accept with count != 0: latch count, direction and channel; outByte = {hostCmdRead_in, hostCmdChan_in}, outValid = 1, go to S_HDR.
REQ-009 Each consume SHALL advance S_HDR->S_CNT0->S_CNT1->S_CNT2->S_CNT3, loading count bytes [31:24], [23:16], [15:8], [7:0] big-endian into outByte.
REQ-010 Consume in S_CNT3 SHALL go to S_RDATA (read command, outValid cleared) or S_WDATA (write command).
REQ-011 In S_WDATA: hostReady_out = (loadLeft != 0) and (outValid = 0 or consume this cycle); each host transfer loads outByte and decrements loadLeft; back-to-back one byte per cycle SHALL be sustained.
REQ-012 S_WDATA SHALL go to S_IDLE on the edge where loadLeft = 0 and the last byte is consumed.
REQ-013 In S_RDATA: fx2GotRoom_out = (rxLeft != 0) and (hostValid_out = 0 or hostReady_in = 1); capture = edge with fx2FifoSel_in = 1, fx2Write_in = 0, fx2GotRoom_out = 1.
REQ-014 Capture SHALL load hostData_out from fx2Data_io, set hostValid_out and decrement rxLeft; hostValid_out SHALL clear on hostReady_in when no capture occurs.
REQ-015 Capture of the final byte (rxLeft = 1) SHALL go to S_RPKT.
REQ-016 S_RPKT SHALL last exactly one cycle, then go to S_IDLE.
REQ-017 In S_RPKT, fx2PktEnd_in low SHALL be expected iff count[8:0] != 0; a mismatch SHALL set protoErr_out.
REQ-018 fx2PktEnd_in low in any state SHALL pulse hostPktEnd_out on the next cycle.
REQ-019 fx2PktEnd_in low outside S_RPKT SHALL set protoErr_out.
REQ-020 fx2Write_in low with fx2FifoSel_in = 1 while fx2GotRoom_out = 0 SHALL set protoErr_out and discard the byte.
REQ-021 fx2GotRoom_out SHALL be 0 outside S_RDATA; hostReady_out SHALL be 0 outside S_WDATA.
REQ-022 Counters SHALL be 32-bit unsigned and SHALL never wrap below 0.

Reset
REQ-023 Reset low SHALL asynchronously force S_IDLE and clear outValid, hostValid_out, all counters and protoErr_out; it SHALL also release fx2Data_io to high-Z, whatever operation is in progress.
REQ-024 During reset: all outputs SHALL be 0 except hostCmdReady_out = 1 (effective after release) and fx2Data_io = Z.

Verification
REQ-025 Host write, chan 0x05, count 3, data AA BB CC, paired with comm_fpga -> bus carries 05 00 00 00 03 AA BB CC; busy_out low after the final consume.
REQ-026 Host read, chan 0x02, count 4, FPGA sends 11 22 33 44 -> header 0x82; hostData_out yields 11 22 33 44; hostPktEnd_out pulses once; protoErr_out = 0.
REQ-027 Host read, count 512 -> no PktEnd, protoErr_out = 0; forced PktEnd in S_RPKT -> protoErr_out = 1.
REQ-028 Host read with hostReady_in held 0 -> after one capture fx2GotRoom_out = 0; no data lost once hostReady_in returns to 1.
REQ-029 Command with count 0 -> no fx2GotData_out assertion and hostCmdReady_out stays 1.
REQ-030 Reset asserted mid-S_WDATA at byte 2 of 6 -> next cycle S_IDLE, fx2GotData_out = 0, fx2Data_io = Z; a new command then completes correctly.

Source files
------------

// File: rtl/fx2_emu_if.sv
// fx2_emu_if: FX2 FIFO strobes/flags plus host command and stream handshakes for fx2_emu
// master = host/FX2 side driving the *_in signals, slave = fx2_emu driving the *_out signals
interface fx2_emu_if;
    logic        fx2FifoSel_in;
    logic        fx2Read_in;
    logic        fx2GotData_out;
    logic        fx2Write_in;
    logic        fx2GotRoom_out;
    logic        fx2PktEnd_in;
    logic        hostCmdValid_in;
    logic        hostCmdReady_out;
    logic        hostCmdRead_in;
    logic [6:0]  hostCmdChan_in;
    logic [31:0] hostCmdCount_in;
    logic [7:0]  hostData_in;
    logic        hostValid_in;
    logic        hostReady_out;
    logic [7:0]  hostData_out;
    logic        hostValid_out;
    logic        hostReady_in;
    logic        hostPktEnd_out;
    logic        protoErr_out;
    logic        busy_out;
    modport master (
        output fx2FifoSel_in, fx2Read_in, fx2Write_in, fx2PktEnd_in,
        output hostCmdValid_in, hostCmdRead_in, hostCmdChan_in, hostCmdCount_in,
        output hostData_in, hostValid_in, hostReady_in,
        input  fx2GotData_out, fx2GotRoom_out, hostCmdReady_out, hostReady_out,
        input  hostData_out, hostValid_out, hostPktEnd_out, protoErr_out, busy_out
    );
    modport slave (
        input  fx2FifoSel_in, fx2Read_in, fx2Write_in, fx2PktEnd_in,
        input  hostCmdValid_in, hostCmdRead_in, hostCmdChan_in, hostCmdCount_in,
        input  hostData_in, hostValid_in, hostReady_in,
        output fx2GotData_out, fx2GotRoom_out, hostCmdReady_out, hostReady_out,
        output hostData_out, hostValid_out, hostPktEnd_out, protoErr_out, busy_out
    );
endinterface

// File: rtl/fx2_emu.sv
// fx2_emu: emulates the FX2 side of comm_fpga, turning host commands/streams into 8-bit FIFO traffic
// Ports: clk_in (rising edge), reset_in (async, active-low), fx2Data_io (shared FIFO data bus),
// bus (fx2_emu_if.slave: FX2 strobes/flags, host command handshake, host write/read streams, status)
module fx2_emu (
    input  logic       clk_in,
    input  logic       reset_in,
    inout  wire  [7:0] fx2Data_io,
    fx2_emu_if.slave   bus
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_HDR   = 4'd1;
    localparam logic [3:0] S_CNT0  = 4'd2;
    localparam logic [3:0] S_CNT1  = 4'd3;
    localparam logic [3:0] S_CNT2  = 4'd4;
    localparam logic [3:0] S_CNT3  = 4'd5;
    localparam logic [3:0] S_WDATA = 4'd6;
    localparam logic [3:0] S_RDATA = 4'd7;
    localparam logic [3:0] S_RPKT  = 4'd8;
    logic [3:0]  state_q, state_d;
    logic [7:0]  out_byte_q, out_byte_d, host_data_q, host_data_d;
    logic        out_valid_q, out_valid_d, host_valid_q, host_valid_d;
    logic        is_read_q, is_read_d, pkt_end_q, pkt_end_d, proto_err_q, proto_err_d;
    logic [31:0] count_q, count_d, load_left_q, load_left_d, rx_left_q, rx_left_d;
    logic        consume, accept, host_ready, wr_xfer, got_room, capture, rpkt_bad;
    always_comb begin
        consume     = !bus.fx2FifoSel_in && !bus.fx2Read_in && out_valid_q;
        accept      = bus.hostCmdValid_in && state_q == S_IDLE;
        host_ready  = state_q == S_WDATA && load_left_q != 32'd0 && (!out_valid_q || consume);
        wr_xfer     = host_ready && bus.hostValid_in;
        got_room    = state_q == S_RDATA && rx_left_q != 32'd0 && (!host_valid_q || bus.hostReady_in);
        capture     = bus.fx2FifoSel_in && !bus.fx2Write_in && got_room;
        // a packet end is owed in S_RPKT only when the transfer ended on a short packet
        rpkt_bad    = state_q == S_RPKT && (!bus.fx2PktEnd_in != (count_q[8:0] != 9'd0));
        state_d     = state_q;
        out_byte_d  = out_byte_q;
        out_valid_d = consume ? 1'b0 : out_valid_q;
        is_read_d   = is_read_q;
        count_d     = count_q;
        load_left_d = load_left_q;
        rx_left_d   = rx_left_q;
        host_data_d  = capture ? fx2Data_io : host_data_q;
        host_valid_d = capture || (host_valid_q && !bus.hostReady_in);
        pkt_end_d    = !bus.fx2PktEnd_in;
        proto_err_d  = proto_err_q || rpkt_bad
                    || (!bus.fx2PktEnd_in && state_q != S_RPKT)
                    || (bus.fx2FifoSel_in && !bus.fx2Write_in && !got_room);
        case (state_q)
            S_IDLE: if (accept && bus.hostCmdCount_in != 32'd0) begin
                count_d     = bus.hostCmdCount_in;
                is_read_d   = bus.hostCmdRead_in;
                load_left_d = bus.hostCmdRead_in ? 32'd0 : bus.hostCmdCount_in;
                rx_left_d   = bus.hostCmdRead_in ? bus.hostCmdCount_in : 32'd0;
                out_byte_d  = {bus.hostCmdRead_in, bus.hostCmdChan_in};
                out_valid_d = 1'b1;
                state_d     = S_HDR;
            end
            S_HDR: if (consume) begin
                out_byte_d  = count_q[31:24];
                out_valid_d = 1'b1;
                state_d     = S_CNT0;
            end
            S_CNT0: if (consume) begin
                out_byte_d  = count_q[23:16];
                out_valid_d = 1'b1;
                state_d     = S_CNT1;
            end
            S_CNT1: if (consume) begin
                out_byte_d  = count_q[15:8];
                out_valid_d = 1'b1;
                state_d     = S_CNT2;
            end
            S_CNT2: if (consume) begin
                out_byte_d  = count_q[7:0];
                out_valid_d = 1'b1;
                state_d     = S_CNT3;
            end
            S_CNT3: if (consume) state_d = is_read_q ? S_RDATA : S_WDATA;
            S_WDATA: if (wr_xfer) begin
                out_byte_d  = bus.hostData_in;
                out_valid_d = 1'b1;
                load_left_d = load_left_q - 32'd1;
            end else if (load_left_q == 32'd0 && consume) begin
                state_d = S_IDLE;
            end
            S_RDATA: if (capture) begin
                rx_left_d = rx_left_q - 32'd1;
                state_d   = rx_left_q == 32'd1 ? S_RPKT : S_RDATA;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= S_IDLE;
            out_byte_q   <= 8'd0;
            out_valid_q  <= 1'b0;
            host_data_q  <= 8'd0;
            host_valid_q <= 1'b0;
            is_read_q    <= 1'b0;
            pkt_end_q    <= 1'b0;
            proto_err_q  <= 1'b0;
            count_q      <= 32'd0;
            load_left_q  <= 32'd0;
            rx_left_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            out_byte_q   <= out_byte_d;
            out_valid_q  <= out_valid_d;
            host_data_q  <= host_data_d;
            host_valid_q <= host_valid_d;
            is_read_q    <= is_read_d;
            pkt_end_q    <= pkt_end_d;
            proto_err_q  <= proto_err_d;
            count_q      <= count_d;
            load_left_q  <= load_left_d;
            rx_left_q    <= rx_left_d;
        end
    end
    // the bus is released while reset is held, regardless of the strobes
    assign fx2Data_io           = (reset_in && !bus.fx2FifoSel_in && bus.fx2Write_in) ? out_byte_q : 8'bz;
    assign bus.fx2GotData_out   = out_valid_q;
    assign bus.fx2GotRoom_out   = got_room;
    assign bus.hostCmdReady_out = state_q == S_IDLE;
    assign bus.hostReady_out    = host_ready;
    assign bus.hostData_out     = host_data_q;
    assign bus.hostValid_out    = host_valid_q;
    assign bus.hostPktEnd_out   = pkt_end_q;
    assign bus.protoErr_out     = proto_err_q;
    assign bus.busy_out         = state_q != S_IDLE;
endmodule

// File: tb/tb_fx2_emu.sv
// tb_fx2_emu: directed self-checking bench for fx2_emu
module tb_fx2_emu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    tri1 [7:0] fx2_data;
    logic tb_drv = 1'b0;
    logic [7:0] tb_byte = 8'd0;
    int n_chk = 0;
    int n_pass = 0;
    int pkt_cnt = 0;
    logic [7:0] src[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic room_stall;
    fx2_emu_if bus();
    fx2_emu dut (.clk_in(clk), .reset_in(rst_n), .fx2Data_io(fx2_data), .bus(bus));
    assign fx2_data = tb_drv ? tb_byte : 8'bz;
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.hostPktEnd_out) pkt_cnt++;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask
    task automatic check_got(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
    endtask
    task automatic cmd(input logic rd, input logic [6:0] ch, input logic [31:0] cnt);
        bus.hostCmdValid_in = 1'b1;
        bus.hostCmdRead_in  = rd;
        bus.hostCmdChan_in  = ch;
        bus.hostCmdCount_in = cnt;
        @(posedge clk); #1;
        bus.hostCmdValid_in = 1'b0;
    endtask
    // reads OUT bytes with read held low while streaming src on the host write port
    task automatic run_out(input int n, output int cycles);
        int k = 0;
        int c = 0;
        got = {};
        bus.fx2FifoSel_in = 1'b0;
        bus.fx2Read_in    = 1'b0;
        bus.hostValid_in  = src.size() > 0;
        bus.hostData_in   = src.size() > 0 ? src[0] : 8'd0;
        while (got.size() < n && c < 200) begin
            #1;
            if (bus.fx2GotData_out) got.push_back(fx2_data);
            if (bus.hostValid_in && bus.hostReady_out) k++;
            @(posedge clk); #1;
            bus.hostValid_in = k < src.size();
            bus.hostData_in  = k < src.size() ? src[k] : 8'd0;
            c++;
        end
        bus.fx2Read_in   = 1'b1;
        bus.hostValid_in = 1'b0;
        cycles = c;
        if (got.size() < n) check("out_timeout", got.size(), n);
    endtask
    // feeds src into the IN FIFO, collecting host read data; pe asserts PktEnd in the cycle after the last byte
    task automatic run_in(input int n, input int stall, input bit pe);
        int k = 0;
        int c = 0;
        bit pend = 1'b0;
        bit now = 1'b0;
        got = {};
        room_stall = 1'b0;
        bus.fx2FifoSel_in = 1'b1;
        while ((got.size() < n || pend) && c < 2000) begin
            now = pend;
            pend = 1'b0;
            bus.hostReady_in = c >= stall;
            bus.fx2PktEnd_in = !(now && pe);
            #1;
            if (!bus.hostReady_in && k > 0 && bus.fx2GotRoom_out) room_stall = 1'b1;
            if (bus.hostValid_out && bus.hostReady_in) got.push_back(bus.hostData_out);
            if (bus.fx2GotRoom_out && k < n) begin
                bus.fx2Write_in = 1'b0;
                tb_drv  = 1'b1;
                tb_byte = src[k];
                k++;
                pend = k == n;
            end else begin
                bus.fx2Write_in = 1'b1;
                tb_drv = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        bus.fx2Write_in  = 1'b1;
        bus.fx2PktEnd_in = 1'b1;
        bus.hostReady_in = 1'b1;
        tb_drv = 1'b0;
        if (c >= 2000) check("in_timeout", c, 0);
    endtask
    task automatic pulse_reset();
        bus.fx2FifoSel_in = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask
    initial begin
        int cyc;
        int pc0;
        int bad;
        bus.fx2FifoSel_in   = 1'b0;
        bus.fx2Read_in      = 1'b1;
        bus.fx2Write_in     = 1'b1;
        bus.fx2PktEnd_in    = 1'b1;
        bus.hostCmdValid_in = 1'b0;
        bus.hostCmdRead_in  = 1'b0;
        bus.hostCmdChan_in  = 7'd0;
        bus.hostCmdCount_in = 32'd0;
        bus.hostData_in     = 8'd0;
        bus.hostValid_in    = 1'b0;
        bus.hostReady_in    = 1'b1;
        #12;
        check("rst_busy", bus.busy_out, 0);
        check("rst_gotdata", bus.fx2GotData_out, 0);
        check("rst_gotroom", bus.fx2GotRoom_out, 0);
        check("rst_hostready", bus.hostReady_out, 0);
        check("rst_hostvalid", bus.hostValid_out, 0);
        check("rst_pktend", bus.hostPktEnd_out, 0);
        check("rst_err", bus.protoErr_out, 0);
        check("rst_cmdready", bus.hostCmdReady_out, 1);
        check("rst_bus_z", fx2_data, 8'hff);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        src = {8'hAA, 8'hBB, 8'hCC};
        cmd(1'b0, 7'h05, 32'd3);
        run_out(8, cyc);
        exp_q = {8'h05, 8'h00, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        check_got("wr3");
        check("wr3_cycles", cyc, 9);
        check("wr3_busy", bus.busy_out, 0);
        check("wr3_err", bus.protoErr_out, 0);
        src = {};
        cmd(1'b1, 7'h02, 32'd4);
        run_out(5, cyc);
        exp_q = {8'h82, 8'h00, 8'h00, 8'h00, 8'h04};
        check_got("rd4_hdr");
        src = {8'h11, 8'h22, 8'h33, 8'h44};
        pc0 = pkt_cnt;
        run_in(4, 0, 1'b1);
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
        check_got("rd4");
        @(posedge clk); #1;
        check("rd4_pkt", pkt_cnt - pc0, 1);
        check("rd4_err", bus.protoErr_out, 0);
        check("rd4_busy", bus.busy_out, 0);
        src = {};
        cmd(1'b1, 7'h03, 32'd2);
        run_out(5, cyc);
        check("stall_hdr", got[0], 8'h83);
        src = {8'h55, 8'h66};
        run_in(2, 4, 1'b1);
        exp_q = {8'h55, 8'h66};
        check_got("stall");
        check("stall_room", room_stall, 0);
        check("stall_err", bus.protoErr_out, 0);
        for (int p = 0; p < 2; p++) begin
            src = {};
            cmd(1'b1, 7'h01, 32'd512);
            run_out(5, cyc);
            check("rd512_hdr3", got[3], 8'h02);
            for (int i = 0; i < 512; i++) src.push_back(i[7:0]);
            pc0 = pkt_cnt;
            run_in(512, 0, p == 1);
            bad = 0;
            for (int i = 0; i < 512; i++) if (i >= got.size() || got[i] !== i[7:0]) bad++;
            check("rd512_data", bad, 0);
            @(posedge clk); #1;
            check("rd512_pkt", pkt_cnt - pc0, p);
            check("rd512_err", bus.protoErr_out, p);
        end
        pulse_reset();
        check("clr_err", bus.protoErr_out, 0);
        cmd(1'b0, 7'h09, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("cnt0_gotdata", bus.fx2GotData_out, 0);
            check("cnt0_cmdready", bus.hostCmdReady_out, 1);
            @(posedge clk); #1;
        end
        check("cnt0_err", bus.protoErr_out, 0);
        pc0 = pkt_cnt;
        bus.fx2PktEnd_in = 1'b0;
        @(posedge clk); #1;
        bus.fx2PktEnd_in = 1'b1;
        check("idle_pktend_err", bus.protoErr_out, 1);
        check("idle_pktend_pulse", bus.hostPktEnd_out, 1);
        @(posedge clk); #1;
        check("idle_pktend_once", pkt_cnt - pc0, 1);
        pulse_reset();
        bus.fx2FifoSel_in = 1'b1;
        bus.fx2Write_in = 1'b0;
        @(posedge clk); #1;
        bus.fx2Write_in = 1'b1;
        check("noroom_err", bus.protoErr_out, 1);
        pulse_reset();
        src = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        cmd(1'b0, 7'h04, 32'd6);
        run_out(7, cyc);
        check("mid_byte2", got[6], 8'h02);
        check("mid_busy", bus.busy_out, 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_gotdata", bus.fx2GotData_out, 0);
        check("mid_rst_bus_z", fx2_data, 8'hff);
        @(posedge clk); #1;
        check("mid_rst_busy", bus.busy_out, 0);
        check("mid_rst_cmdready", bus.hostCmdReady_out, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        src = {8'hD1, 8'hD2};
        cmd(1'b0, 7'h7F, 32'd2);
        run_out(7, cyc);
        exp_q = {8'h7F, 8'h00, 8'h00, 8'h00, 8'h02, 8'hD1, 8'hD2};
        check_got("after_rst");
        check("after_rst_busy", bus.busy_out, 0);
        check("after_rst_err", bus.protoErr_out, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
